// File: rtl/ka_93bit_seq.sv
// ka_93bit_seq: 93x93 carry-less multiplier that time-shares one external KA_47bit core (LO, HI, MID).
// Optional feature macro KA93_SEQ_MULREG_EN: registers mul_y and adds a DRAIN state (+1 cycle latency).
module ka_93bit_seq (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [92:0]  a,
    input  logic [92:0]  b,
    output logic         busy,
    output logic         done,
    output logic [184:0] y,
    output logic [46:0]  mul_a,
    output logic [46:0]  mul_b,
    input  logic [92:0]  mul_y
);

    localparam int unsigned OP_W   = 93;
    localparam int unsigned HALF_W = 47;
    localparam int unsigned PROD_W = 2 * HALF_W - 1;
    localparam int unsigned RES_W  = 2 * OP_W - 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LO    = 3'd1,
        S_HI    = 3'd2,
        S_MID   = 3'd3,
        S_DRAIN = 3'd4
    } state_e;

    state_e              state_q, state_d;
    logic [OP_W-1:0]     ra_q, ra_d;
    logic [OP_W-1:0]     rb_q, rb_d;
    logic [PROD_W-1:0]   pl_q, pl_d;
    logic [PROD_W-1:0]   ph_q, ph_d;
    logic [PROD_W-1:0]   pm_q, pm_d;
    logic [RES_W-1:0]    y_q, y_d;
    logic                done_q, done_d;

    logic [HALF_W-1:0]   ra_lo, ra_hi, rb_lo, rb_hi;
    logic [PROD_W-1:0]   prod;
    logic [PROD_W-1:0]   mid;
    logic [RES_W-1:0]    y_comb;

    assign ra_lo = ra_q[HALF_W-1:0];
    assign ra_hi = HALF_W'(ra_q[OP_W-1:HALF_W]);
    assign rb_lo = rb_q[HALF_W-1:0];
    assign rb_hi = HALF_W'(rb_q[OP_W-1:HALF_W]);

`ifdef KA93_SEQ_MULREG_EN
    // Core result is retimed one cycle; captures below lag the driving state by one edge.
    logic [PROD_W-1:0] mul_y_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mul_y_q <= '0;
        end else begin
            mul_y_q <= mul_y;
        end
    end

    assign prod = mul_y_q;
`else
    assign prod = mul_y;
`endif

    // Karatsuba overlap; the middle product arrives in the same cycle as the combine.
    assign mid    = pl_q ^ ph_q ^ prod;
    assign y_comb = RES_W'(pl_q)
                  ^ (RES_W'(mid)  << HALF_W)
                  ^ (RES_W'(ph_q) << (2 * HALF_W));

    assign busy = (state_q != S_IDLE);
    assign done = done_q;
    assign y    = y_q;

    always_comb begin
        state_d = state_q;
        ra_d    = ra_q;
        rb_d    = rb_q;
        pl_d    = pl_q;
        ph_d    = ph_q;
        pm_d    = pm_q;
        y_d     = y_q;
        done_d  = 1'b0;
        mul_a   = '0;
        mul_b   = '0;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    ra_d    = a;
                    rb_d    = b;
                    state_d = S_LO;
                end
            end
            S_LO: begin
                mul_a   = ra_lo;
                mul_b   = rb_lo;
`ifndef KA93_SEQ_MULREG_EN
                pl_d    = prod;
`endif
                state_d = S_HI;
            end
            S_HI: begin
                mul_a   = ra_hi;
                mul_b   = rb_hi;
`ifdef KA93_SEQ_MULREG_EN
                pl_d    = prod;
`else
                ph_d    = prod;
`endif
                state_d = S_MID;
            end
            S_MID: begin
                mul_a   = ra_lo ^ ra_hi;
                mul_b   = rb_lo ^ rb_hi;
`ifdef KA93_SEQ_MULREG_EN
                ph_d    = prod;
                state_d = S_DRAIN;
`else
                pm_d    = prod;
                y_d     = y_comb;
                done_d  = 1'b1;
                state_d = S_IDLE;
`endif
            end
            S_DRAIN: begin
`ifdef KA93_SEQ_MULREG_EN
                pm_d    = prod;
                y_d     = y_comb;
                done_d  = 1'b1;
`endif
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ra_q    <= '0;
            rb_q    <= '0;
            pl_q    <= '0;
            ph_q    <= '0;
            pm_q    <= '0;
            y_q     <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            ra_q    <= ra_d;
            rb_q    <= rb_d;
            pl_q    <= pl_d;
            ph_q    <= ph_d;
            pm_q    <= pm_d;
            y_q     <= y_d;
            done_q  <= done_d;
        end
    end

endmodule

// File: tb/tb_ka_93bit_seq.sv
// Self-checking bench for ka_93bit_seq: bitwise carry-less reference model plus directed literal cases.
module tb_ka_93bit_seq;

`ifdef KA93_SEQ_MULREG_EN
    localparam int unsigned LAT = 4;
`else
    localparam int unsigned LAT = 3;
`endif

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [92:0]  a;
    logic [92:0]  b;
    logic         busy;
    logic         done;
    logic [184:0] y;
    logic [46:0]  mul_a;
    logic [46:0]  mul_b;
    logic [92:0]  mul_y;

    int checks   = 0;
    int failures = 0;

    ka_93bit_seq dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .y     (y),
        .mul_a (mul_a),
        .mul_b (mul_b),
        .mul_y (mul_y)
    );

    always #5 clk = ~clk;

    function automatic logic [184:0] clmul93(input logic [92:0] x, input logic [92:0] z);
        logic [184:0] r;
        r = '0;
        for (int i = 0; i < 93; i++) begin
            if (z[i]) r = r ^ (185'(x) << i);
        end
        return r;
    endfunction

    function automatic logic [92:0] clmul47(input logic [46:0] x, input logic [46:0] z);
        logic [92:0] r;
        r = '0;
        for (int i = 0; i < 47; i++) begin
            if (z[i]) r = r ^ (93'(x) << i);
        end
        return r;
    endfunction

    function automatic logic [92:0] rand93();
        return 93'({$urandom(), $urandom(), $urandom()});
    endfunction

    // Stand-in for the external KA_47bit core.
    always_comb mul_y = clmul47(mul_a, mul_b);

    task automatic chk(input string nm, input logic [184:0] act, input logic [184:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Reference model: one job at a time, result due LAT edges after acceptance.
    int unsigned  ecnt      = 0;
    int unsigned  acc_edge  = 0;
    int unsigned  done_edge = 0;
    int unsigned  free_edge = 0;
    bit           pending   = 1'b0;
    logic [92:0]  acc_a     = '0;
    logic [92:0]  acc_b     = '0;
    logic [184:0] m_y       = '0;
    logic         m_done    = 1'b0;
    logic         m_busy    = 1'b0;
    logic [46:0]  m_ma      = '0;
    logic [46:0]  m_mb      = '0;

    task automatic model_step();
        logic [46:0] lo_a, hi_a, lo_b, hi_b;
        if (rst) begin
            ecnt      = 0;
            pending   = 1'b0;
            free_edge = 0;
            m_y       = '0;
            m_done    = 1'b0;
        end else begin
            ecnt++;
            m_done = 1'b0;
            if (pending && ecnt == done_edge) begin
                m_y     = clmul93(acc_a, acc_b);
                m_done  = 1'b1;
                pending = 1'b0;
            end
            if (start && !pending && ecnt >= free_edge) begin
                pending   = 1'b1;
                acc_a     = a;
                acc_b     = b;
                acc_edge  = ecnt;
                done_edge = ecnt + LAT;
                free_edge = ecnt + LAT + 1;
            end
        end
        lo_a   = acc_a[46:0];
        hi_a   = 47'(acc_a >> 47);
        lo_b   = acc_b[46:0];
        hi_b   = 47'(acc_b >> 47);
        m_busy = pending;
        m_ma   = '0;
        m_mb   = '0;
        if (pending) begin
            case (ecnt - acc_edge)
                0: begin m_ma = lo_a;        m_mb = lo_b;        end
                1: begin m_ma = hi_a;        m_mb = hi_b;        end
                2: begin m_ma = lo_a ^ hi_a; m_mb = lo_b ^ hi_b; end
                default: begin m_ma = '0;    m_mb = '0;          end
            endcase
        end
    endtask

    always @(posedge clk or posedge rst) model_step();

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        chk("busy",  185'(busy),  185'(m_busy));
        chk("done",  185'(done),  185'(m_done));
        chk("y",     y,           m_y);
        chk("mul_a", 185'(mul_a), 185'(m_ma));
        chk("mul_b", 185'(mul_b), 185'(m_mb));
    end

    task automatic run_one(input string nm, input logic [92:0] op_a, input logic [92:0] op_b,
                           input logic [184:0] exp_y, input bit poke);
        int n;
        int extra;
        @(negedge clk);
        a     = op_a;
        b     = op_b;
        start = 1'b1;
        n     = 0;
        do begin
            @(negedge clk);
            n++;
            if (!done) begin
                start = poke;
                a     = rand93();
                b     = rand93();
            end
        end while (!done && n < int'(4 * LAT));
        start = 1'b0;
        chk({nm, "_latency"}, 185'(n), 185'(LAT + 1));
        chk({nm, "_y"}, y, exp_y);
        chk({nm, "_busy_at_done"}, 185'(busy), 185'(0));
        extra = 0;
        repeat (2 * LAT) begin
            @(negedge clk);
            if (done) extra++;
        end
        chk({nm, "_extra_done"}, 185'(extra), 185'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n_done;
        int cyc;
        int last;
        logic [92:0] ones;

        rst   = 1'b0;
        start = 1'b0;
        a     = '0;
        b     = '0;
        #1 rst = 1'b1;
        @(negedge clk);
        chk("reset_y",    y,              185'(0));
        chk("reset_busy", 185'(busy),     185'(0));
        chk("reset_mul",  185'(mul_a),    185'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        ones = '1;
        run_one("one",   93'(1), 93'(1), 185'(1), 1'b0);
        run_one("three", 93'(3), 93'(3), 185'(5), 1'b0);
        run_one("cross", 93'(1) << 47, 93'(1) << 46, 185'(1) << 93, 1'b0);
        run_one("top",   93'(1) << 92, 93'(1) << 92, 185'(1) << 184, 1'b0);
        run_one("ones",  ones, ones, clmul93(ones, ones), 1'b0);
        run_one("ignore_busy_start", 93'(5), 93'(7), 185'(27), 1'b1);

        // Back-to-back with start held high and fresh operands every cycle.
        n_done = 0;
        cyc    = 0;
        last   = 0;
        @(negedge clk);
        start = 1'b1;
        a     = rand93();
        b     = rand93();
        while (n_done < 50 && cyc < 60 * int'(LAT + 1)) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                if (n_done > 0) chk("thru_gap", 185'(cyc - last), 185'(LAT + 1));
                last = cyc;
                n_done++;
            end
            a = rand93();
            b = rand93();
        end
        start = 1'b0;
        chk("thru_count", 185'(n_done), 185'(50));
        repeat (LAT + 2) @(negedge clk);

        // Asynchronous reset while the HI sub-product is on the core.
        a     = (93'(1) << 50) | 93'(1);
        b     = (93'(1) << 60) | 93'(3);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_busy",  185'(busy),  185'(0));
        chk("async_rst_done",  185'(done),  185'(0));
        chk("async_rst_y",     y,           185'(0));
        chk("async_rst_mul_a", 185'(mul_a), 185'(0));
        chk("async_rst_mul_b", 185'(mul_b), 185'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        run_one("post_rst_hi", 93'(1) << 47, 93'(1) << 47, 185'(1) << 94, 1'b0);
        run_one("post_rst_mix", (93'(1) << 50) | 93'(1), (93'(1) << 60) | 93'(3),
                clmul93((93'(1) << 50) | 93'(1), (93'(1) << 60) | 93'(3)), 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
